// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types and constants for the L1-I / L1-D to L2 line-port arbiter.
package l1_arb_types;

  localparam int L1_LINE_W = 256;
  localparam int L1_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/l1_l2_arb_picker.sv
// Combinational grant selection between I-cache and D-cache requests.
// L1_ARB_ROUND_ROBIN_EN: alternate on ties using last grant; otherwise D wins ties.
module l1_l2_arb_picker
  import l1_arb_types::*;
(
`ifdef L1_ARB_ROUND_ROBIN_EN
  input  arb_grant_t i_last_grant,
`endif
  input  logic       i_req_i,
  input  logic       i_req_d,
  output arb_grant_t o_grant
);

  always_comb begin
    o_grant = GRANT_I;
    if (i_req_i && i_req_d) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
      o_grant = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
      o_grant = GRANT_D;
`endif
    end else if (i_req_d) begin
      o_grant = GRANT_D;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 line port between L1-I and L1-D; one outstanding request.
// L1_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed D priority).
module l1_l2_arbiter
  import l1_arb_types::*;
#(
  parameter int LINE_W = L1_LINE_W,
  parameter int ADDR_W = L1_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  input  logic              l2_mem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  arb_grant_t        w_grant;
  logic              w_req_i;
  logic              w_req_d;
  logic              w_take;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  assign w_req_i = i_mem_read;
  assign w_req_d = d_mem_read | d_mem_write;
  assign w_take  = (r_state == IDLE) && (w_req_i || w_req_d);

`ifdef L1_ARB_ROUND_ROBIN_EN
  arb_grant_t r_last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_last_grant <= GRANT_D;
    else if (w_take) r_last_grant <= w_grant;
  end
`endif

  l1_l2_arb_picker u_picker (
`ifdef L1_ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last_grant),
`endif
    .i_req_i      (w_req_i),
    .i_req_d      (w_req_d),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:             if (w_take) w_next_state = (w_grant == GRANT_I) ? SERVE_I : SERVE_D;
      SERVE_I, SERVE_D: if (l2_mem_resp) w_next_state = IDLE;
      default:          w_next_state = IDLE;
    endcase
  end

  // Write wins over an (illegal) simultaneous D read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      if (w_grant == GRANT_I) begin
        r_read  <= 1'b1;
        r_write <= 1'b0;
        r_addr  <= i_mem_address;
        r_wdata <= '0;
      end else begin
        r_read  <= d_mem_read & ~d_mem_write;
        r_write <= d_mem_write;
        r_addr  <= d_mem_address;
        r_wdata <= d_mem_wdata;
      end
    end
  end

  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    i_mem_resp     = 1'b0;
    d_mem_resp     = 1'b0;
    if (r_state != IDLE) begin
      l2_mem_read    = r_read;
      l2_mem_write   = r_write;
      l2_mem_address = r_addr;
      l2_mem_wdata   = r_wdata;
    end
    if (r_state == SERVE_I) i_mem_resp = l2_mem_resp;
    if (r_state == SERVE_D) d_mem_resp = l2_mem_resp;
  end

  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(d_mem_read && d_mem_write));

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter; the bench itself plays the L2 and both L1s.
module tb_l1_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_read;
  logic [31:0]  i_mem_address;
  logic [255:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [31:0]  d_mem_address;
  logic [255:0] d_mem_wdata;
  logic [255:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         l2_mem_read;
  logic         l2_mem_write;
  logic [31:0]  l2_mem_address;
  logic [255:0] l2_mem_wdata;
  logic [255:0] l2_mem_rdata;
  logic         l2_mem_resp;

  int n_chk  = 0;
  int n_fail = 0;

  l1_l2_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_read     (i_mem_read),
    .i_mem_address  (i_mem_address),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_resp     (i_mem_resp),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_wdata    (d_mem_wdata),
    .d_mem_rdata    (d_mem_rdata),
    .d_mem_resp     (d_mem_resp),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_rdata   (l2_mem_rdata),
    .l2_mem_resp    (l2_mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive point sits 2 time units after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called at the drive point of the IDLE cycle in which the request is presented.
  // Returns at the drive point of the cycle after the L2 resp.
  task automatic txn(input string tag, input logic exp_rd, input logic exp_wr,
                     input logic [31:0] exp_addr, input logic [255:0] exp_wd,
                     input int lat, input logic exp_i, input logic mid_chg);
    logic [255:0] rd_pat;
    rd_pat = {8{exp_addr ^ 32'h5a5a_0f0f}};
    #1;
    chk({tag, ":idle"}, 256'({l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp}), '0);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == lat) begin
        l2_mem_resp  = 1'b1;
        l2_mem_rdata = rd_pat;
      end
      #1;
      chk({tag, ":rd"},    256'(l2_mem_read),    256'(exp_rd));
      chk({tag, ":wr"},    256'(l2_mem_write),   256'(exp_wr));
      chk({tag, ":addr"},  256'(l2_mem_address), 256'(exp_addr));
      chk({tag, ":wdata"}, l2_mem_wdata,         exp_wd);
      chk({tag, ":iresp"}, 256'(i_mem_resp),     256'((c == lat) && exp_i));
      chk({tag, ":dresp"}, 256'(d_mem_resp),     256'((c == lat) && !exp_i));
      if (mid_chg && c == 1) d_mem_address = 32'h0000_0400;
    end
    if (exp_i) chk({tag, ":irdata"}, i_mem_rdata, rd_pat);
    else       chk({tag, ":drdata"}, d_mem_rdata, rd_pat);
    tick();
    l2_mem_resp = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":ctl"}, 256'({l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp}), '0);
    chk({tag, ":addr"}, 256'(l2_mem_address), '0);
    chk({tag, ":wdata"}, l2_mem_wdata, '0);
  endtask

  initial begin
    logic exp_i;
    rst           = 1'b0;
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    l2_mem_rdata  = {32{8'h3c}};
    l2_mem_resp   = 1'b0;

    // Reset state and rdata pass-through.
    repeat (2) tick();
    #1;
    chk_quiet("reset");
    chk("reset:irdata", i_mem_rdata, {32{8'h3c}});
    chk("reset:drdata", d_mem_rdata, {32{8'h3c}});
    rst = 1'b1;
    tick();

    // Tie directly after reset.
    i_mem_read    = 1'b1;
    i_mem_address = 32'h0000_0100;
    d_mem_read    = 1'b1;
    d_mem_address = 32'h0000_0200;
`ifdef L1_ARB_ROUND_ROBIN_EN
    txn("tie_first", 1'b1, 1'b0, 32'h0000_0100, '0, 3, 1'b1, 1'b0);
    i_mem_read = 1'b0;
    txn("tie_second", 1'b1, 1'b0, 32'h0000_0200, '0, 3, 1'b0, 1'b0);
    d_mem_read = 1'b0;
`else
    txn("tie_first", 1'b1, 1'b0, 32'h0000_0200, '0, 3, 1'b0, 1'b0);
    d_mem_read = 1'b0;
    txn("tie_second", 1'b1, 1'b0, 32'h0000_0100, '0, 3, 1'b1, 1'b0);
    i_mem_read = 1'b0;
`endif

    // Both held for four transactions.
    i_mem_read    = 1'b1;
    i_mem_address = 32'h0000_1100;
    d_mem_read    = 1'b1;
    d_mem_address = 32'h0000_1200;
    for (int k = 0; k < 4; k++) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      txn($sformatf("alt%0d", k), 1'b1, 1'b0, exp_i ? 32'h0000_1100 : 32'h0000_1200,
          '0, 2, exp_i, 1'b0);
    end
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;

    // I-only read, L2 resp after 5 cycles.
    i_mem_read    = 1'b1;
    i_mem_address = 32'h0000_1000;
    txn("iread", 1'b1, 1'b0, 32'h0000_1000, '0, 5, 1'b1, 1'b0);
    i_mem_read = 1'b0;

    // D write.
    d_mem_write   = 1'b1;
    d_mem_address = 32'h8000_0020;
    d_mem_wdata   = {32{8'hA5}};
    txn("dwrite", 1'b0, 1'b1, 32'h8000_0020, {32{8'hA5}}, 3, 1'b0, 1'b0);
    d_mem_write = 1'b0;
    d_mem_wdata = '0;

    // D address changes mid-service; L2 address must hold.
    d_mem_read    = 1'b1;
    d_mem_address = 32'h0000_0300;
    txn("dmid", 1'b1, 1'b0, 32'h0000_0300, '0, 4, 1'b0, 1'b1);
    d_mem_read = 1'b0;

    // Reset two cycles into SERVE_D with I pending.
    d_mem_write   = 1'b1;
    d_mem_address = 32'h0000_0500;
    d_mem_wdata   = {32{8'h11}};
    tick();
    i_mem_read    = 1'b1;
    i_mem_address = 32'h0000_0600;
    tick();
    #1;
    chk("pre_rst:wr", 256'(l2_mem_write), 256'(1'b1));
    rst         = 1'b0;
    d_mem_write = 1'b0;
    d_mem_wdata = '0;
    #1;
    chk_quiet("in_rst");
    tick();
    #1;
    chk_quiet("in_rst2");
    rst = 1'b1;
    txn("rst_i", 1'b1, 1'b0, 32'h0000_0600, '0, 2, 1'b1, 1'b0);
    i_mem_read = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Arbiter that shares the single CPU-side line port of the unified L2 cache between the L1 instruction cache and the L1 data cache. It takes line-granular read and write requests from both L1s, grants one at a time, registers the granted request onto the L2 port, and routes `l2_mem_resp` and read data back to the winner. It sits between the two L1 cache controllers and `l2_cache`.

## Interface
- `LINE_W`, 256, cache line width in bits
- `ADDR_W`, 32, line address width in bits (low 5 bits are zero)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_mem_read`  in  1  I-cache line read request
- `i_mem_address`  in  ADDR_W  I-cache line address
- `i_mem_rdata`  out  LINE_W  line data to I-cache
- `i_mem_resp`  out  1  I-cache request complete
- `d_mem_read`  in  1  D-cache line read request
- `d_mem_write`  in  1  D-cache line write request
- `d_mem_address`  in  ADDR_W  D-cache line address
- `d_mem_wdata`  in  LINE_W  D-cache write line
- `d_mem_rdata`  out  LINE_W  line data to D-cache
- `d_mem_resp`  out  1  D-cache request complete
- `l2_mem_read`  out  1  read request to L2
- `l2_mem_write`  out  1  write request to L2
- `l2_mem_address`  out  ADDR_W  L2 line address
- `l2_mem_wdata`  out  LINE_W  L2 write line
- `l2_mem_rdata`  in  LINE_W  L2 read line
- `l2_mem_resp`  in  1  L2 request complete

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`.
- `IDLE`: no request, so stay. Exactly one requester: grant it. Both requesting: apply the tie policy (see Configuration). On grant, capture address, write data, and the read/write kind into request registers, then go to `SERVE_I` or `SERVE_D`.
- `SERVE_x`: `l2_mem_read`/`l2_mem_write`/`l2_mem_address`/`l2_mem_wdata` are driven only from the request registers. They are held until `l2_mem_resp`. In the resp cycle, `x_mem_resp = 1` combinationally and the state returns to `IDLE`.
- `i_mem_rdata` and `d_mem_rdata` are both wired to `l2_mem_rdata` at all times. Each is only valid while its own resp is high.
- Requesters hold their request stable until they see resp. They deassert it, or present a new one, in the cycle after resp. `IDLE` samples requests fresh.
- A request from the non-granted cache waits; it is never dropped.
- `d_mem_read` and `d_mem_write` high together is illegal. Write wins and a simulation assertion fires.
- A requester that drops its request mid-service does not abort the L2 transaction. The transaction completes and its resp is still issued.
- Reset (any time, including mid-transaction): state goes to `IDLE`, request registers clear, `last_grant` is set to D. All outputs are 0 while in reset and in `IDLE`, except the rdata pass-throughs.

## Timing
- Request seen in `IDLE` at cycle 0: L2 request is asserted from cycle 1.
- L2 resp at cycle k gives the requester resp at cycle k, the same cycle.
- Added latency is exactly one cycle per transaction.
- Back-to-back: the earliest next L2 request is cycle k+2, since `IDLE` spends one cycle at k+1.
- Only one L2 request is ever outstanding. `l2_mem_read` and `l2_mem_write` are never both high.

## Configuration
- `L1_ARB_ROUND_ROBIN_EN` defined: a 1-bit `last_grant` register, updated on every grant.
  - On a tie, grant the cache not in `last_grant`.
  - Reset value is D, so the first tie grants I.
- `L1_ARB_ROUND_ROBIN_EN` undefined: fixed priority, D-cache always wins a tie. `last_grant` is not built.

## Structure
- Shared package `l1_arb_types`:
  - `arb_state_t` (IDLE/SERVE_I/SERVE_D)
  - `arb_grant_t` (GRANT_I/GRANT_D)
  - `L1_LINE_W`, `L1_ADDR_W` constants
- One sub-module, `l1_l2_arb_picker`: combinational. Takes the two request-valid bits plus `last_grant` and returns an `arb_grant_t`. The FSM, request registers, and resp routing live in the top.

## Test plan
- I-only read of 0x0000_1000, L2 resp after 5 cycles: `l2_mem_read` rises 1 cycle after request, address 0x0000_1000, `i_mem_resp` on the same cycle as `l2_mem_resp`, `d_mem_resp` stays 0.
- D write of 0x8000_0020 with wdata all-0xA5: `l2_mem_write = 1`, `l2_mem_wdata` = all-0xA5, `l2_mem_read = 0`, `d_mem_resp` on the L2 resp cycle.
- Simultaneous I read of 0x100 and D read of 0x200 directly after reset:
  - With macro: I is served first, then D.
  - Without macro: D is served first, then I.
  - The second request is issued 2 cycles after the first resp.
- Both held continuously for 4 transactions with the macro defined: grants alternate I, D, I, D. Without the macro, D takes all grants while D keeps requesting.
- `d_mem_address` changes mid-service from 0x300 to 0x400: `l2_mem_address` stays 0x300 until resp.
- Assert `rst` low 2 cycles into `SERVE_D`: outputs go to 0 asynchronously, state is `IDLE`, and a pending I request is granted in the first cycle after release.
